// File: rtl/debouncer_bank.sv
// Bank of CHANNELS debouncers: 2-flop synchroniser + immediate-response/lockout FSM per input.
// Latency: out/rise/fall update on the third rising edge after in changes; no backpressure (en freezes the FSMs).
module debouncer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] s0;
  logic [CHANNELS-1:0] s1;

  // Synchroniser runs every cycle, independent of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= in;
      s1 <= s0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             rise_q;
    logic             fall_q;
    logic             rise_d;
    logic             fall_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= LOW;
        cnt_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else if (en) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end else begin
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        LOW: begin
          cnt_d = '0;
          if (s1[i]) begin
            state_d = WAIT_HIGH;
            rise_d  = 1'b1;
          end
        end
        WAIT_HIGH: begin
          // Counter MSB marks the end of lockout; it is cleared on exit so it never wraps.
          if (cnt_q[WIDTH-1]) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HIGH: begin
          cnt_d = '0;
          if (!s1[i]) begin
            state_d = WAIT_LOW;
            fall_d  = 1'b1;
          end
        end
        WAIT_LOW: begin
          if (cnt_q[WIDTH-1]) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end

    assign out[i]  = (state_q == WAIT_HIGH) || (state_q == HIGH);
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

  assign any_rise = |rise;

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank (4 channels, WIDTH=4 -> 9-cycle lockout) with a level/lockout-count model.
module tb_debouncer_bank;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int LOCK = (1 << (W - 1)) + 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [CH-1:0] din;
  logic [CH-1:0] out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          any_rise;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: delayed input copies, debounced level, remaining lockout cycles, pulses.
  logic [CH-1:0] m_d1   = '0;
  logic [CH-1:0] m_d2   = '0;
  logic [CH-1:0] m_out  = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  int            m_lock [CH];

  debouncer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (din),
    .out      (out),
    .rise     (rise),
    .fall     (fall),
    .any_rise (any_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    logic [CH-1:0] seen;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      for (int c = 0; c < CH; c++) m_lock[c] = 0;
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = din;
      m_rise = '0;
      m_fall = '0;
      if (en) begin
        for (int c = 0; c < CH; c++) begin
          if (m_lock[c] > 0) begin
            m_lock[c] = m_lock[c] - 1;
          end else if (seen[c] != m_out[c]) begin
            m_out[c]  = seen[c];
            m_lock[c] = LOCK;
            m_rise[c] = seen[c];
            m_fall[c] = ~seen[c];
          end
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) m_lock[c] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      n_tests++;
      if ({out, rise, fall, any_rise} !== {m_out, m_rise, m_fall, |m_rise}) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t out=%b/%b rise=%b/%b fall=%b/%b any=%b/%b (dut/model)",
                 $time, out, m_out, rise, m_rise, fall, m_fall, any_rise, |m_rise);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [4:0] pat;
    int rcnt, fcnt, lowcnt, stay, bad3, fseen, r5, rfz;
    int rt [CH];

    rst = 1'b1; en = 1'b1; din = '0;
    tick(); tick();
    chk("rst_out",  32'(out), 0);
    chk("rst_rise", 32'(rise), 0);
    chk("rst_fall", 32'(fall), 0);
    chk("rst_any",  32'(any_rise), 0);
    rst = 1'b0;
    tick(); tick();

    // Clean press
    din = 4'b0001;
    tick(); chk("t1_e0_out", 32'(out), 0);
    tick(); chk("t1_e1_out", 32'(out), 0);
    tick(); chk("t1_out", 32'(out), 1); chk("t1_rise", 32'(rise), 1); chk("t1_any", 32'(any_rise), 1);
    tick(); chk("t1_rise_clr", 32'(rise), 0); chk("t1_out_hold", 32'(out), 1);
    repeat (12) tick();
    chk("t1_out_high", 32'(out), 1);
    din = '0;
    tick(); tick(); tick();
    chk("t1_fall", 32'(fall), 1); chk("t1_out_low", 32'(out), 0);
    repeat (14) tick();

    // Bounce rejection
    rcnt = 0; fcnt = 0; lowcnt = 0;
    pat = 5'b10101;
    for (int i = 0; i < 21; i++) begin
      din[0] = (i < 5) ? pat[i] : 1'b1;
      tick();
      if (rise[0]) rcnt++;
      if (fall[0]) fcnt++;
      if (rcnt > 0 && !out[0]) lowcnt++;
    end
    chk("t2_rise_count", rcnt, 1);
    chk("t2_fall_count", fcnt, 0);
    chk("t2_out_low_cycles", lowcnt, 0);
    din = '0;
    repeat (16) tick();

    // Release during lockout
    din = 4'b0001;
    tick(); tick(); tick();
    chk("t3_rise", 32'(rise), 1);
    din = '0;
    stay = 0;
    for (int k = 4; k <= 12; k++) begin
      tick();
      if (out[0] && !fall[0]) stay++;
    end
    chk("t3_hold_cycles", stay, 9);
    tick(); chk("t3_fall", 32'(fall), 1); chk("t3_out", 32'(out), 0);
    tick(); chk("t3_fall_clr", 32'(fall), 0);
    repeat (12) tick();

    // Independence
    din = 4'b0101;
    bad3 = 0;
    for (int c = 0; c < CH; c++) rt[c] = -1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      for (int c = 0; c < CH; c++) if (rise[c] && rt[c] < 0) rt[c] = t;
      if (out[3]) bad3++;
      if (t == 5) din[1] = 1'b1;
    end
    chk("t4_rise0", rt[0], 3);
    chk("t4_rise2", rt[2], 3);
    chk("t4_rise1", rt[1], 8);
    chk("t4_out3_high", bad3, 0);
    din = '0;
    repeat (16) tick();

    // Enable gating mid-lockout
    din = 4'b0001;
    fseen = -1; r5 = -1; rfz = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (rise[0] && r5 < 0) r5 = t;
      if (fall[0] && fseen < 0) fseen = t;
      if (t >= 6 && t <= 15 && (rise != '0 || fall != '0)) rfz++;
      if (t == 3) din = '0;
      if (t == 5) en = 1'b0;
      if (t == 15) en = 1'b1;
    end
    chk("t5_rise", r5, 3);
    chk("t5_pulse_in_freeze", rfz, 0);
    chk("t5_fall_time", fseen, 23);
    repeat (14) tick();

    // Reset mid-operation: ch1 in HIGH, ch0 in WAIT_HIGH
    din = 4'b0010;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 10) din[0] = 1'b1;
    end
    chk("t6_pre_out", 32'(out), 32'h3);
    rst = 1'b1;
    tick();
    chk("t6_rst_out", 32'(out), 0);
    chk("t6_rst_fall", 32'(fall), 0);
    rst = 1'b0;
    tick(); chk("t6_e1_out", 32'(out), 0);
    tick(); chk("t6_e2_out", 32'(out), 0);
    tick(); chk("t6_rise", 32'(rise), 32'h3); chk("t6_out", 32'(out), 32'h3);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Multi-channel, parametrised successor to the single-input debouncer. It cleans up to CHANNELS independent asynchronous mechanical inputs (buttons, switches) and drives a level output per channel. Each input passes through a 2-flop synchroniser, then an immediate-response/lockout FSM. Each channel also emits one-cycle rise and fall pulses, so downstream logic (MIPS I/O registers, step/run controls) needs no separate edge detector.

## Interface
- CHANNELS, 4: number of independent inputs, 1..32.
- WIDTH, 20: lockout counter width, ≥2. Lockout length is 2^(WIDTH-1)+1 enabled cycles.
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global clock enable; gates FSM and counter updates in all channels.
- in  in  CHANNELS  raw asynchronous inputs, active-high.
- out  out  CHANNELS  debounced levels.
- rise  out  CHANNELS  one-cycle pulse on each 0→1 of out[i].
- fall  out  CHANNELS  one-cycle pulse on each 1→0 of out[i].
- any_rise  out  1  OR of rise[CHANNELS-1:0].

## Operation
- **Synchroniser**
  - Per channel: s0 <= in[i], s1 <= s0.
  - Runs every cycle regardless of en. Cleared by rst.
  - The FSM sees only s1.
- **Per-channel FSM** (2-bit state, WIDTH-bit counter), updated only when en=1:
  - LOW: out=0, counter held at 0. If s1=1, go to WAIT_HIGH.
  - WAIT_HIGH: out=1, counter += 1 each enabled cycle. If counter[WIDTH-1]=1, go to HIGH. s1 is ignored.
  - HIGH: out=1, counter held at 0. If s1=0, go to WAIT_LOW.
  - WAIT_LOW: out=0, counter += 1. If counter[WIDTH-1]=1, go to LOW. s1 is ignored.
- **Output behaviour**
  - out is decoded from the registered state only, so it is glitch-free.
  - out reacts to the first edge, then ignores all bounce for the lockout period.
  - If the input level differs from out when a WAIT state ends, the FSM passes through the stable state for one enabled cycle, then re-enters the opposite WAIT state.
- **Edge pulses**
  - rise[i] is registered: set to 1 on the clock edge where the state goes LOW→WAIT_HIGH, and 0 on every other edge.
  - fall[i] is the same for HIGH→WAIT_LOW.
  - Each pulse therefore coincides exactly with the first cycle of the new out level.
- **Counter arithmetic**
  - Unsigned, WIDTH bits.
  - Cannot wrap: the WAIT state exits at 2^(WIDTH-1), and counter returns to 0 in LOW/HIGH.
- **Channel independence**: channels share only clk, rst and en. Simultaneous events on several channels are handled independently in the same cycle.
- **en=0**
  - State and counters freeze; synchroniser keeps running.
  - rise/fall are 0 at every edge where en=0.
- **rst=1**, taking effect at the next edge:
  - s0, s1, counters ← 0; all states ← LOW.
  - out, rise, fall, any_rise ← 0.
  - Holds for any state, including mid-lockout.
  - No fall pulse is generated for a channel forced from HIGH/WAIT_HIGH to LOW by reset.

## Timing
- Reset values of all outputs: 0.
- Input-to-output latency with en=1: in[i] changes before edge E0; s0 captures at E0, s1 at E1; state, out[i] and rise/fall update at E2.
  - out is valid after the third rising edge: 2 cycles of synchroniser plus 1 cycle of FSM.
- Lockout: a WAIT state lasts 2^(WIDTH-1)+1 enabled cycles; disabled cycles do not count.
- Minimum interval between successive rise pulses on one channel: 2·(2^(WIDTH-1)+1)+2 enabled cycles.
- any_rise is combinational OR of registered rise bits; same cycle as rise.

## Test plan
1. **Clean press**: CHANNELS=4, WIDTH=4, en=1. in[0] 0→1 and held.
   - out[0]=1 and rise[0]=any_rise=1 after the 3rd edge.
   - rise[0] is 0 on the next cycle.
   - out[0] stays 1; state reaches HIGH 9 cycles later.
2. **Bounce rejection**: same setup. in[0] toggles 1,0,1,0,1 on successive cycles right after the press.
   - Exactly one rise[0].
   - out[0] stays 1 throughout; no fall[0].
3. **Release during lockout**: in[0] rises, then returns to 0 at cycle 3 and stays low.
   - out[0] stays 1 until WAIT_HIGH ends (9 cycles), then HIGH for 1 cycle.
   - Then out[0]=0 with fall[0]=1 for one cycle.
4. **Independence**: in[0] and in[2] rise on the same cycle; in[1] rises 5 cycles later.
   - rise[0] and rise[2] are coincident.
   - rise[1] is exactly 5 cycles later; out[3] stays 0.
5. **Enable gating**: hold en=0 for 10 cycles in the middle of WAIT_HIGH.
   - Counter and state frozen; no rise/fall during the freeze.
   - Lockout completes exactly 9 enabled cycles after entry.
6. **Reset mid-operation**: assert rst for 1 cycle while channel 0 is in WAIT_HIGH and channel 1 is in HIGH.
   - Next cycle: out=0 and no fall pulses.
   - With in[1] still high, channel 1 re-enters WAIT_HIGH with rise[1] 3 edges after rst deasserts, because the synchroniser was cleared.
